// File: rtl/datapath_pkg.sv
// Shared types and constants for the register-file datapath: operand width,
// register count, ALU opcodes, SIMD lane encodings and a lanewise adder.
package datapath_pkg;

  localparam int WIDTH = 32;
  localparam int NREGS = 16;
  localparam int IDXW  = $clog2(NREGS);

  typedef logic [IDXW-1:0]  reg_idx_t;
  typedef logic [WIDTH-1:0] word_t;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_SHL  = 3'd5,
    OP_SHR  = 3'd6,
    OP_PASS = 3'd7
  } alu_op_t;

  // Encoding 2'b11 behaves exactly like VEC_8.
  localparam logic [1:0] VEC_32 = 2'b00;
  localparam logic [1:0] VEC_16 = 2'b01;
  localparam logic [1:0] VEC_8  = 2'b10;

  function automatic word_t lane_msbs(input logic [1:0] vec);
    word_t m;
    case (vec)
      VEC_32:  m = 32'h8000_0000;
      VEC_16:  m = 32'h8000_8000;
      default: m = 32'h8080_8080;
    endcase
    return m;
  endfunction

  // Clearing each lane's top bit before the add stops any carry leaving a
  // lane; the top bit is then restored as a carry-less xor.
  function automatic word_t lane_add(input word_t a, input word_t b,
                                     input logic [1:0] vec);
    word_t top;
    top = lane_msbs(vec);
    return ((a & ~top) + (b & ~top)) ^ ((a ^ b) & top);
  endfunction

endpackage

// File: rtl/simd_alu.sv
// Combinational ALU that applies one operation per lane across a 32-bit word
// split as 1x32, 2x16 or 4x8 lanes, with nothing crossing a lane boundary.
module simd_alu
  import datapath_pkg::*;
(
  input  word_t      i_x,
  input  word_t      i_y,
  input  alu_op_t    i_op,
  input  logic [1:0] i_vec,
  output word_t      o_result
);

  word_t w_res32;
  word_t w_res16;
  word_t w_res8;

  // Operands arrive zero-extended to the lane; the result is trimmed back to
  // the lane so carries, borrows and shifted-out bits are discarded.
  function automatic word_t lane_op(input word_t x, input word_t y,
                                    input alu_op_t op, input logic [4:0] shMask,
                                    input word_t laneMask);
    logic [4:0] sh;
    word_t      r;
    sh = y[4:0] & shMask;
    case (op)
      OP_ADD:  r = x + y;
      OP_SUB:  r = x - y;
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_XOR:  r = x ^ y;
      OP_SHL:  r = x << sh;
      OP_SHR:  r = x >> sh;
      default: r = x;
    endcase
    return r & laneMask;
  endfunction

  always_comb begin
    w_res32 = lane_op(i_x, i_y, i_op, 5'd31, 32'hFFFF_FFFF);
    w_res16 = '0;
    for (int i = 0; i < 2; i++) begin
      w_res16 = w_res16 | (lane_op((i_x >> (16 * i)) & 32'h0000_FFFF,
                                   (i_y >> (16 * i)) & 32'h0000_FFFF,
                                   i_op, 5'd15, 32'h0000_FFFF) << (16 * i));
    end
    w_res8 = '0;
    for (int i = 0; i < 4; i++) begin
      w_res8 = w_res8 | (lane_op((i_x >> (8 * i)) & 32'h0000_00FF,
                                 (i_y >> (8 * i)) & 32'h0000_00FF,
                                 i_op, 5'd7, 32'h0000_00FF) << (8 * i));
    end
  end

  always_comb begin
    case (i_vec)
      VEC_32:  o_result = w_res32;
      VEC_16:  o_result = w_res16;
      default: o_result = w_res8;
    endcase
  end

endmodule

// File: rtl/datapath_unit.sv
// Single-cycle datapath: 16x32 register file, operand selection, two SIMD ALU
// lanes with optional accumulate, and dual same-edge writeback.
module datapath_unit
  import datapath_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       op,
  input  logic             form,
  input  logic [1:0]       vec,
  input  logic [IDXW-1:0]  A,
  input  logic [IDXW-1:0]  B,
  input  logic [IDXW-1:0]  C,
  input  logic [IDXW-1:0]  D,
  input  logic [3:0]       zero_reg,
  input  logic [IDXW-1:0]  Y1,
  input  logic [IDXW-1:0]  Y2,
  input  logic [1:0]       write,
  input  logic             const_a,
  input  logic [WIDTH-1:0] constant
);

  word_t registers [NREGS];

  word_t w_opA;
  word_t w_opB;
  word_t w_opC;
  word_t w_opD;
  word_t w_f1;
  word_t w_f2;
  word_t w_result1;
  word_t w_result2;

  // Zeroing is applied last, so it overrides the immediate on operand A.
  always_comb begin
    w_opA = zero_reg[0] ? '0 : (const_a ? constant : registers[A]);
    w_opB = zero_reg[1] ? '0 : registers[B];
    w_opC = zero_reg[2] ? '0 : registers[C];
    w_opD = zero_reg[3] ? '0 : registers[D];
  end

  simd_alu u_alu1 (
    .i_x      (w_opA),
    .i_y      (w_opB),
    .i_op     (alu_op_t'(op)),
    .i_vec    (vec),
    .o_result (w_f1)
  );

  simd_alu u_alu2 (
    .i_x      (w_opC),
    .i_y      (w_opD),
    .i_op     (alu_op_t'(op)),
    .i_vec    (vec),
    .o_result (w_f2)
  );

  // Accumulate form reuses the first lane's result for both outputs.
  always_comb begin
    if (form) begin
      w_result1 = lane_add(w_f1, w_opC, vec);
      w_result2 = lane_add(w_f1, w_opD, vec);
    end else begin
      w_result1 = w_f1;
      w_result2 = w_f2;
    end
  end

  // Y1 is written after Y2 so result1 wins when both target one register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        registers[i] <= '0;
      end
    end else begin
      if (write[1]) begin
        registers[Y2] <= w_result2;
      end
      if (write[0]) begin
        registers[Y1] <= w_result1;
      end
    end
  end

endmodule

// File: tb/tb_datapath_unit.sv
// Self-checking bench for datapath_unit: table-driven vectors feed a scoreboard
// of expected register writes, plus a hand-written asynchronous reset sequence.
module tb_datapath_unit;

  logic        clk;
  logic        rst_n;
  logic [2:0]  op;
  logic        form;
  logic [1:0]  vec;
  logic [3:0]  A, B, C, D;
  logic [3:0]  zero_reg;
  logic [3:0]  Y1, Y2;
  logic [1:0]  write;
  logic        const_a;
  logic [31:0] constant;

  int checks;
  int errors;

  typedef struct {
    logic [2:0]  op;
    logic        form;
    logic [1:0]  vec;
    logic [3:0]  a, b, c, d;
    logic [3:0]  zr;
    logic [3:0]  y1, y2;
    logic [1:0]  wr;
    logic        ca;
    logic [31:0] k;
    logic [31:0] e1, e2;
  } vector_t;

  typedef struct packed {
    logic [3:0]  idx;
    logic [31:0] val;
  } sb_t;

  vector_t     tbl[$];
  sb_t         sbq[$];
  logic [31:0] shadow [16];

  datapath_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .op       (op),
    .form     (form),
    .vec      (vec),
    .A        (A),
    .B        (B),
    .C        (C),
    .D        (D),
    .zero_reg (zero_reg),
    .Y1       (Y1),
    .Y2       (Y2),
    .write    (write),
    .const_a  (const_a),
    .constant (constant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vector_t mk(input logic [2:0] o, input logic f, input logic [1:0] v,
                                 input logic [3:0] a, input logic [3:0] b,
                                 input logic [3:0] c, input logic [3:0] d,
                                 input logic [3:0] zr, input logic [3:0] y1,
                                 input logic [3:0] y2, input logic [1:0] wr,
                                 input logic ca, input logic [31:0] k,
                                 input logic [31:0] e1, input logic [31:0] e2);
    vector_t t;
    t.op = o; t.form = f; t.vec = v;
    t.a = a; t.b = b; t.c = c; t.d = d;
    t.zr = zr; t.y1 = y1; t.y2 = y2; t.wr = wr;
    t.ca = ca; t.k = k; t.e1 = e1; t.e2 = e2;
    return t;
  endfunction

  // Immediate load: constant on A, B zeroed, add.
  function automatic vector_t imm(input logic [3:0] y, input logic [31:0] val);
    return mk(3'd0, 1'b0, 2'b00, 4'd0, 4'd0, 4'd0, 4'd0, 4'b1110, y, 4'd0,
              2'b01, 1'b1, val, val, 32'd0);
  endfunction

  task automatic compare(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic checkAll(input int id);
    for (int i = 0; i < 16; i++) begin
      compare($sformatf("vec%0d hold r%0d", id, i), dut.registers[i], shadow[i]);
    end
  endtask

  task automatic checkOutput(input int id);
    sb_t e;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      compare($sformatf("vec%0d write r%0d", id, e.idx), dut.registers[e.idx], e.val);
      shadow[e.idx] = e.val;
    end
    checkAll(id);
  endtask

  task automatic applyStimulus(input vector_t t, input int id);
    @(negedge clk);
    op = t.op; form = t.form; vec = t.vec;
    A = t.a; B = t.b; C = t.c; D = t.d;
    zero_reg = t.zr; Y1 = t.y1; Y2 = t.y2; write = t.wr;
    const_a = t.ca; constant = t.k;
    if (t.wr[1] && !(t.wr[0] && t.y1 == t.y2)) sbq.push_back({t.y2, t.e2});
    if (t.wr[0]) sbq.push_back({t.y1, t.e1});
    @(posedge clk);
    #1;
    checkOutput(id);
  endtask

  // Reset is pulsed between edges and held across one edge with writes enabled.
  task automatic resetSequence();
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < 16; i++) shadow[i] = 32'd0;
    #1;
    checkAll(100);
    op = 3'd0; form = 1'b0; vec = 2'b00; zero_reg = 4'b1110;
    const_a = 1'b1; constant = 32'h0000_ABCD; Y1 = 4'd3; Y2 = 4'd4; write = 2'b11;
    @(posedge clk);
    #1;
    checkAll(101);
    @(negedge clk);
    write = 2'b00;
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0;
    op = '0; form = 1'b0; vec = '0; A = '0; B = '0; C = '0; D = '0;
    zero_reg = '0; Y1 = '0; Y2 = '0; write = '0; const_a = 1'b0; constant = '0;
    for (int i = 0; i < 16; i++) shadow[i] = 32'd0;

    tbl.push_back(imm(4'd1, 32'd5));
    tbl.push_back(imm(4'd2, 32'd7));
    tbl.push_back(imm(4'd1, 32'h00FF_FFFF));
    tbl.push_back(imm(4'd2, 32'h0001_0001));
    tbl.push_back(mk(3'd0, 0, 2'b01, 1, 2, 0, 0, 4'b0000, 3, 0, 2'b01, 0, 0, 32'h0100_0000, 0));
    tbl.push_back(mk(3'd0, 0, 2'b00, 1, 2, 0, 0, 4'b0000, 3, 0, 2'b01, 0, 0, 32'h0101_0000, 0));
    tbl.push_back(mk(3'd0, 0, 2'b10, 1, 2, 0, 0, 4'b0000, 3, 0, 2'b01, 0, 0, 32'h0000_FF00, 0));
    tbl.push_back(imm(4'd1, 32'd6));
    tbl.push_back(imm(4'd2, 32'd3));
    tbl.push_back(mk(3'd1, 0, 2'b00, 1, 2, 1, 2, 4'b0000, 4, 5, 2'b11, 0, 0, 32'd3, 32'd3));
    tbl.push_back(mk(3'd1, 0, 2'b00, 1, 2, 2, 1, 4'b0000, 6, 6, 2'b11, 0, 0, 32'd3, 32'hFFFF_FFFD));
    tbl.push_back(imm(4'd1, 32'h0000_00F0));
    tbl.push_back(imm(4'd2, 32'h0000_003C));
    tbl.push_back(imm(4'd3, 32'd1));
    tbl.push_back(imm(4'd4, 32'd2));
    tbl.push_back(mk(3'd2, 1, 2'b00, 1, 2, 3, 4, 4'b0000, 7, 8, 2'b11, 0, 0, 32'h31, 32'h32));
    tbl.push_back(mk(3'd2, 1, 2'b00, 1, 2, 3, 4, 4'b0100, 7, 8, 2'b11, 0, 0, 32'h30, 32'h32));
    tbl.push_back(imm(4'd9, 32'h0011_0001));
    tbl.push_back(mk(3'd5, 0, 2'b01, 0, 9, 0, 0, 4'b0000, 10, 0, 2'b01, 1, 32'h8001_8001, 32'h0002_0002, 0));
    tbl.push_back(mk(3'd5, 0, 2'b00, 0, 9, 0, 0, 4'b0000, 10, 0, 2'b01, 1, 32'h8001_8001, 32'h0003_0002, 0));
    tbl.push_back(mk(3'd6, 0, 2'b10, 0, 9, 0, 0, 4'b0000, 11, 0, 2'b01, 1, 32'h8001_8001, 32'h8000_8000, 0));
    tbl.push_back(mk(3'd6, 0, 2'b01, 0, 9, 0, 0, 4'b0000, 11, 0, 2'b01, 1, 32'h8001_8001, 32'h4000_4000, 0));
    tbl.push_back(mk(3'd6, 0, 2'b11, 0, 9, 0, 0, 4'b0000, 12, 0, 2'b01, 1, 32'h8001_8001, 32'h8000_8000, 0));
    tbl.push_back(mk(3'd1, 0, 2'b01, 0, 9, 0, 0, 4'b0000, 13, 0, 2'b01, 1, 32'd0, 32'hFFEF_FFFF, 0));
    tbl.push_back(mk(3'd1, 0, 2'b00, 0, 9, 0, 0, 4'b0000, 13, 0, 2'b01, 1, 32'd0, 32'hFFEE_FFFF, 0));
    tbl.push_back(mk(3'd3, 0, 2'b00, 0, 9, 0, 0, 4'b0000, 14, 0, 2'b01, 1, 32'hF0F0_0000, 32'hF0F1_0001, 0));
    tbl.push_back(mk(3'd4, 0, 2'b00, 0, 9, 0, 0, 4'b0000, 14, 0, 2'b01, 1, 32'hFFFF_0000, 32'hFFEE_0001, 0));
    tbl.push_back(mk(3'd7, 0, 2'b00, 0, 9, 0, 0, 4'b0000, 15, 0, 2'b01, 1, 32'h1234_5678, 32'h1234_5678, 0));
    tbl.push_back(mk(3'd7, 0, 2'b00, 0, 9, 0, 0, 4'b0001, 15, 0, 2'b01, 1, 32'h1234_5678, 32'd0, 0));
    tbl.push_back(imm(4'd0, 32'hDEAD_BEEF));
    tbl.push_back(mk(3'd0, 0, 2'b00, 1, 2, 3, 4, 4'b0000, 1, 2, 2'b00, 1, 32'h5555_5555, 0, 0));
    tbl.push_back(imm(4'd11, 32'd1));
    tbl.push_back(mk(3'd7, 1, 2'b10, 0, 0, 11, 9, 4'b0010, 12, 13, 2'b11, 1, 32'h0000_00FF, 32'h0000_0000, 32'h0011_0000));
    tbl.push_back(mk(3'd7, 1, 2'b00, 0, 0, 11, 9, 4'b0010, 12, 13, 2'b11, 1, 32'h0000_00FF, 32'h0000_0100, 32'h0011_0100));

    #12;
    checkAll(99);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      if (i == 2) resetSequence();
      applyStimulus(tbl[i], i);
    end

    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard drain: got %0d entries, expected 0", sbq.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
